// File: rtl/syn_sram_acc_pkg.sv
// Shared types and constants for the SRAM access controller.
package syn_sram_acc_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 18;
  localparam int WAIT_CNT_W = 4;

  // Controller access sequencing states
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_ACC   = 3'd1,
    WR_SETUP = 3'd2,
    WR_PULSE = 3'd3,
    WR_HOLD  = 3'd4
  } sram_fsm_t;

  // True for every state in which the controller owns the data pins
  function automatic logic is_wr_state(input sram_fsm_t s);
    return (s == WR_SETUP) || (s == WR_PULSE) || (s == WR_HOLD);
  endfunction

endpackage

// File: rtl/syn_sram_acc_ctrlr.sv
// Responder for single-word read/write requests that drives an external
// asynchronous SRAM through a timed FSM. Every pin and bus output comes
// straight from a flop, so the SRAM sees glitch-free strobes.
module syn_sram_acc_ctrlr
  import syn_sram_acc_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk_ir,
  input  logic              rst_il,
  input  logic              rd_en,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rdy,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              collision_o,
  output logic [ADDR_W-1:0] sram_addr_od,
  inout  wire  [DATA_W-1:0] sram_dq_iod,
  output logic              sram_ce_n_od,
  output logic              sram_oe_n_od,
  output logic              sram_we_n_od,
  output logic              sram_ub_n_od,
  output logic              sram_lb_n_od
);

  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_CYCLES);
  localparam logic [WAIT_CNT_W-1:0] CNT_ZERO  = {WAIT_CNT_W{1'b0}};
  localparam logic [WAIT_CNT_W-1:0] CNT_ONE   = {{(WAIT_CNT_W-1){1'b0}}, 1'b1};

  sram_fsm_t             state_r;
  sram_fsm_t             state_nxt_s;
  logic [WAIT_CNT_W-1:0] wait_cnt_r;
  logic [WAIT_CNT_W-1:0] wait_cnt_nxt_s;

  logic                  rdy_r;
  logic                  rd_valid_r;
  logic [DATA_W-1:0]     rd_data_r;
  logic                  collision_r;
  logic [ADDR_W-1:0]     sram_addr_r;
  logic [DATA_W-1:0]     wr_data_r;
  logic                  dq_oe_r;
  logic                  ce_n_r;
  logic                  oe_n_r;
  logic                  we_n_r;

  logic                  rdy_nxt_s;
  logic                  ce_n_nxt_s;
  logic                  oe_n_nxt_s;
  logic                  we_n_nxt_s;
  logic                  dq_oe_nxt_s;

  logic                  accept_s;
  logic                  rd_done_s;

  // A request is taken only in a cycle where rdy is already showing high
  assign accept_s  = rdy_r & (rd_en | wr_en);
  // Last read-access cycle: the SRAM data is stable and gets captured
  assign rd_done_s = (state_r == RD_ACC) && (state_nxt_s == IDLE);

  // State register
  always_ff @(posedge clk_ir or negedge rst_il) begin
    if (!rst_il) begin
      state_r    <= IDLE;
      wait_cnt_r <= CNT_ZERO;
    end else begin
      state_r    <= state_nxt_s;
      wait_cnt_r <= wait_cnt_nxt_s;
    end
  end

  // Next-state decode; a simultaneous read and write request resolves to the write
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          if (wr_en) begin
            state_nxt_s = WR_SETUP;
          end else begin
            state_nxt_s = RD_ACC;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RD_ACC: begin
        if (wait_cnt_r == CNT_ZERO) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RD_ACC;
        end
      end
      WR_SETUP: state_nxt_s = WR_PULSE;
      WR_PULSE: begin
        if (wait_cnt_r == CNT_ZERO) begin
          state_nxt_s = WR_HOLD;
        end else begin
          state_nxt_s = WR_PULSE;
        end
      end
      WR_HOLD:  state_nxt_s = IDLE;
      default:  state_nxt_s = IDLE;
    endcase
  end

  // Wait counter: loaded when a timed state is entered, counts down while in it
  always_comb begin
    wait_cnt_nxt_s = wait_cnt_r;
    if (((state_nxt_s == RD_ACC) && (state_r != RD_ACC)) ||
        ((state_nxt_s == WR_PULSE) && (state_r != WR_PULSE))) begin
      wait_cnt_nxt_s = WAIT_LOAD;
    end else if (((state_r == RD_ACC) || (state_r == WR_PULSE)) && (wait_cnt_r != CNT_ZERO)) begin
      wait_cnt_nxt_s = wait_cnt_r - CNT_ONE;
    end else begin
      wait_cnt_nxt_s = wait_cnt_r;
    end
  end

  // Pin and handshake values for the state being entered
  always_comb begin
    rdy_nxt_s   = 1'b0;
    ce_n_nxt_s  = 1'b1;
    oe_n_nxt_s  = 1'b1;
    we_n_nxt_s  = 1'b1;
    dq_oe_nxt_s = is_wr_state(state_nxt_s);
    case (state_nxt_s)
      IDLE:     rdy_nxt_s  = 1'b1;
      RD_ACC: begin
        ce_n_nxt_s = 1'b0;
        oe_n_nxt_s = 1'b0;
      end
      WR_SETUP: ce_n_nxt_s = 1'b0;
      WR_PULSE: begin
        ce_n_nxt_s = 1'b0;
        we_n_nxt_s = 1'b0;
      end
      WR_HOLD:  ce_n_nxt_s = 1'b0;
      default: begin
        rdy_nxt_s   = 1'b0;
        dq_oe_nxt_s = 1'b0;
      end
    endcase
  end

  // Output, address and data registers; collision flag is sticky until reset
  always_ff @(posedge clk_ir or negedge rst_il) begin
    if (!rst_il) begin
      rdy_r       <= 1'b0;
      rd_valid_r  <= 1'b0;
      rd_data_r   <= {DATA_W{1'b0}};
      collision_r <= 1'b0;
      sram_addr_r <= {ADDR_W{1'b0}};
      wr_data_r   <= {DATA_W{1'b0}};
      dq_oe_r     <= 1'b0;
      ce_n_r      <= 1'b1;
      oe_n_r      <= 1'b1;
      we_n_r      <= 1'b1;
    end else begin
      rdy_r      <= rdy_nxt_s;
      rd_valid_r <= rd_done_s;
      dq_oe_r    <= dq_oe_nxt_s;
      ce_n_r     <= ce_n_nxt_s;
      oe_n_r     <= oe_n_nxt_s;
      we_n_r     <= we_n_nxt_s;
      if (accept_s) begin
        sram_addr_r <= addr;
        wr_data_r   <= wr_data;
      end
      if (accept_s && rd_en && wr_en) begin
        collision_r <= 1'b1;
      end
      if (rd_done_s) begin
        rd_data_r <= sram_dq_iod;
      end
    end
  end

  assign sram_dq_iod  = dq_oe_r ? wr_data_r : {DATA_W{1'bz}};
  assign rdy          = rdy_r;
  assign rd_valid     = rd_valid_r;
  assign rd_data      = rd_data_r;
  assign collision_o  = collision_r;
  assign sram_addr_od = sram_addr_r;
  assign sram_ce_n_od = ce_n_r;
  assign sram_oe_n_od = oe_n_r;
  assign sram_we_n_od = we_n_r;
  // Both byte lanes always enabled together with the chip
  assign sram_ub_n_od = ce_n_r;
  assign sram_lb_n_od = ce_n_r;

endmodule

// File: tb/tb_syn_sram_acc_ctrlr.sv
// Directed bench for syn_sram_acc_ctrlr: three instances (WAIT_CYCLES 1, 0, 3)
// share one behavioural SRAM array. While an instance's chip is deselected the
// bench drives a fixed idle pattern on its data bus, so a released bus reads
// back as that pattern and any stray controller drive disturbs it.
module tb_syn_sram_acc_ctrlr;

  localparam logic [15:0] KEEP = 16'hA5A5;

  logic        clk = 1'b0;
  logic        rst_il;
  logic        rd_en [3];
  logic        wr_en [3];
  logic [17:0] addr [3];
  logic [15:0] wr_data [3];
  logic        rdy [3];
  logic        rd_valid [3];
  logic [15:0] rd_data [3];
  logic        collision [3];
  logic [17:0] sram_addr [3];
  logic        ce_n [3];
  logic        oe_n [3];
  logic        we_n [3];
  logic        ub_n [3];
  logic        lb_n [3];
  wire  [15:0] dq0;
  wire  [15:0] dq1;
  wire  [15:0] dq2;
  logic [15:0] mem [0:262143];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  syn_sram_acc_ctrlr #(.WAIT_CYCLES(1)) u0 (
    .clk_ir(clk), .rst_il(rst_il), .rd_en(rd_en[0]), .wr_en(wr_en[0]), .addr(addr[0]),
    .wr_data(wr_data[0]), .rdy(rdy[0]), .rd_valid(rd_valid[0]), .rd_data(rd_data[0]),
    .collision_o(collision[0]), .sram_addr_od(sram_addr[0]), .sram_dq_iod(dq0),
    .sram_ce_n_od(ce_n[0]), .sram_oe_n_od(oe_n[0]), .sram_we_n_od(we_n[0]),
    .sram_ub_n_od(ub_n[0]), .sram_lb_n_od(lb_n[0]));

  syn_sram_acc_ctrlr #(.WAIT_CYCLES(0)) u1 (
    .clk_ir(clk), .rst_il(rst_il), .rd_en(rd_en[1]), .wr_en(wr_en[1]), .addr(addr[1]),
    .wr_data(wr_data[1]), .rdy(rdy[1]), .rd_valid(rd_valid[1]), .rd_data(rd_data[1]),
    .collision_o(collision[1]), .sram_addr_od(sram_addr[1]), .sram_dq_iod(dq1),
    .sram_ce_n_od(ce_n[1]), .sram_oe_n_od(oe_n[1]), .sram_we_n_od(we_n[1]),
    .sram_ub_n_od(ub_n[1]), .sram_lb_n_od(lb_n[1]));

  syn_sram_acc_ctrlr #(.WAIT_CYCLES(3)) u2 (
    .clk_ir(clk), .rst_il(rst_il), .rd_en(rd_en[2]), .wr_en(wr_en[2]), .addr(addr[2]),
    .wr_data(wr_data[2]), .rdy(rdy[2]), .rd_valid(rd_valid[2]), .rd_data(rd_data[2]),
    .collision_o(collision[2]), .sram_addr_od(sram_addr[2]), .sram_dq_iod(dq2),
    .sram_ce_n_od(ce_n[2]), .sram_oe_n_od(oe_n[2]), .sram_we_n_od(we_n[2]),
    .sram_ub_n_od(ub_n[2]), .sram_lb_n_od(lb_n[2]));

  // SRAM read side: chip drives when selected with output enabled, bench idle pattern when deselected
  assign dq0 = ce_n[0] ? KEEP : ((!oe_n[0] && we_n[0]) ? mem[sram_addr[0]] : 16'hzzzz);
  assign dq1 = ce_n[1] ? KEEP : ((!oe_n[1] && we_n[1]) ? mem[sram_addr[1]] : 16'hzzzz);
  assign dq2 = ce_n[2] ? KEEP : ((!oe_n[2] && we_n[2]) ? mem[sram_addr[2]] : 16'hzzzz);

  // SRAM write side: data captured on the rising edge of we_n while the chip is selected
  always @(posedge we_n[0]) if (ce_n[0] == 1'b0) mem[sram_addr[0]] <= dq0;
  always @(posedge we_n[1]) if (ce_n[1] == 1'b0) mem[sram_addr[1]] <= dq1;
  always @(posedge we_n[2]) if (ce_n[2] == 1'b0) mem[sram_addr[2]] <= dq2;

  function automatic logic [15:0] get_dq(input int k);
    case (k)
      0:       return dq0;
      1:       return dq1;
      default: return dq2;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic req(input int k, input logic r, input logic w, input logic [17:0] a,
                     input logic [15:0] d);
    rd_en[k]   = r;
    wr_en[k]   = w;
    addr[k]    = a;
    wr_data[k] = d;
  endtask

  task automatic idle_req(input int k);
    rd_en[k] = 1'b0;
    wr_en[k] = 1'b0;
  endtask

  // Single read started at a negedge where rdy is high; ends at the completing negedge
  task automatic run_read(input int k, input logic [17:0] a, input logic [15:0] exp,
                          input string tag);
    int cnt;
    req(k, 1'b1, 1'b0, a, 16'h0000);
    @(negedge clk);
    idle_req(k);
    cnt = 1;
    while (rdy[k] !== 1'b1 && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    check({tag, "_valid"}, rd_valid[k], 1'b1);
    check({tag, "_data"}, rd_data[k], exp);
  endtask

  // Alternating write/read pairs on 0x3FFF8..0x3FFFF with requests held across busy cycles
  task automatic b2b(input int k, input int w);
    int          cnt;
    logic        prev_rd;
    logic [15:0] expd;
    logic [15:0] d;
    logic [17:0] a;
    prev_rd = 1'b0;
    expd    = 16'h0000;
    for (int j = 0; j <= 16; j++) begin
      if (j > 0) begin
        @(negedge clk);
        cnt = 1;
        while (rdy[k] !== 1'b1 && cnt < 40) begin
          @(negedge clk);
          cnt++;
        end
        check($sformatf("b2b%0d_lat%0d", k, j), cnt, prev_rd ? (w + 2) : (w + 4));
        check($sformatf("b2b%0d_vld%0d", k, j), rd_valid[k], prev_rd);
        if (prev_rd) check($sformatf("b2b%0d_data%0d", k, j), rd_data[k], expd);
      end
      if (j < 16) begin
        a = 18'h3FFF8 + 18'(j / 2);
        d = {4'hD, 4'(k), 4'(j / 2), 4'h9};
        if (j % 2 == 0) begin
          req(k, 1'b0, 1'b1, a, d);
        end else begin
          req(k, 1'b1, 1'b0, a, 16'h0000);
          expd = d;
        end
        prev_rd = (j % 2 == 1);
      end else begin
        idle_req(k);
      end
    end
  endtask

  initial begin
    int vcount;
    int cnt;
    rst_il = 1'b1;
    for (int k = 0; k < 3; k++) req(k, 1'b0, 1'b0, 18'h00000, 16'h0000);
    #1 rst_il = 1'b0;

    // Reset state
    repeat (5) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_rdy%0d", k), rdy[k], 1'b0);
      check($sformatf("rst_ce%0d", k), ce_n[k], 1'b1);
      check($sformatf("rst_oe%0d", k), oe_n[k], 1'b1);
      check($sformatf("rst_we%0d", k), we_n[k], 1'b1);
      check($sformatf("rst_dq%0d", k), get_dq(k), KEEP);
    end
    check("rst_ublb", {ub_n[0], lb_n[0]}, 2'b11);
    check("rst_rdval", rd_valid[0], 1'b0);
    check("rst_rdata", rd_data[0], 16'h0000);
    check("rst_coll", collision[0], 1'b0);
    check("rst_addr", sram_addr[0], 18'h00000);
    rst_il = 1'b1;
    #1 check("rdy_before_edge", rdy[0], 1'b0);
    @(negedge clk);
    for (int k = 0; k < 3; k++) check($sformatf("rdy_after_rel%0d", k), rdy[k], 1'b1);

    // Write 0x1A2B3 <= 0xBEEF with WAIT_CYCLES=1
    req(0, 1'b0, 1'b1, 18'h1A2B3, 16'hBEEF);
    @(negedge clk);
    idle_req(0);
    check("wr1_rdy", rdy[0], 1'b0);
    check("wr1_ce", ce_n[0], 1'b0);
    check("wr1_ublb", {ub_n[0], lb_n[0]}, 2'b00);
    check("wr1_oe", oe_n[0], 1'b1);
    check("wr1_we", we_n[0], 1'b1);
    check("wr1_dq", dq0, 16'hBEEF);
    check("wr1_addr", sram_addr[0], 18'h1A2B3);
    @(negedge clk);
    check("wr2_we", we_n[0], 1'b0);
    check("wr2_oe", oe_n[0], 1'b1);
    check("wr2_dq", dq0, 16'hBEEF);
    @(negedge clk);
    check("wr3_we", we_n[0], 1'b0);
    check("wr3_rdy", rdy[0], 1'b0);
    @(negedge clk);
    check("wr4_we", we_n[0], 1'b1);
    check("wr4_ce", ce_n[0], 1'b0);
    check("wr4_dq", dq0, 16'hBEEF);
    check("wr4_rdy", rdy[0], 1'b0);
    @(negedge clk);
    check("wr5_rdy", rdy[0], 1'b1);
    check("wr5_ce", ce_n[0], 1'b1);
    check("wr5_dq", dq0, KEEP);
    check("wr5_addr_hold", sram_addr[0], 18'h1A2B3);
    check("wr5_rdval", rd_valid[0], 1'b0);
    check("wr_mem", mem[18'h1A2B3], 16'hBEEF);

    // Read 0x1A2B3 back with WAIT_CYCLES=1
    req(0, 1'b1, 1'b0, 18'h1A2B3, 16'h1234);
    @(negedge clk);
    idle_req(0);
    check("rd1_ce", ce_n[0], 1'b0);
    check("rd1_oe", oe_n[0], 1'b0);
    check("rd1_we", we_n[0], 1'b1);
    check("rd1_rdy", rdy[0], 1'b0);
    check("rd1_dq", dq0, 16'hBEEF);
    @(negedge clk);
    check("rd2_oe", oe_n[0], 1'b0);
    check("rd2_rdval", rd_valid[0], 1'b0);
    @(negedge clk);
    check("rd3_rdval", rd_valid[0], 1'b1);
    check("rd3_rdata", rd_data[0], 16'hBEEF);
    check("rd3_rdy", rdy[0], 1'b1);
    check("rd3_oe", oe_n[0], 1'b1);
    @(negedge clk);
    check("rd4_rdval", rd_valid[0], 1'b0);
    check("rd4_rdata_hold", rd_data[0], 16'hBEEF);

    // Simultaneous read and write: the write wins and the collision flag sticks
    req(0, 1'b1, 1'b1, 18'h00010, 16'h5555);
    @(negedge clk);
    idle_req(0);
    check("col_flag", collision[0], 1'b1);
    check("col_oe", oe_n[0], 1'b1);
    check("col_dq", dq0, 16'h5555);
    vcount = 0;
    cnt = 1;
    while (rdy[0] !== 1'b1 && cnt < 40) begin
      @(negedge clk);
      cnt++;
      if (rd_valid[0]) vcount++;
    end
    check("col_lat", cnt, 5);
    check("col_no_rdval", vcount, 0);
    check("col_mem", mem[18'h00010], 16'h5555);
    run_read(0, 18'h00010, 16'h5555, "col_rd");
    check("col_sticky", collision[0], 1'b1);

    // Back-to-back traffic at WAIT_CYCLES=0 and WAIT_CYCLES=3
    b2b(1, 0);
    b2b(2, 3);
    check("b2b_coll1", collision[1], 1'b0);

    // Reset asserted in the middle of the write pulse
    @(negedge clk);
    req(0, 1'b0, 1'b1, 18'h00020, 16'h7777);
    @(negedge clk);
    idle_req(0);
    @(negedge clk);
    check("abort_pre_we", we_n[0], 1'b0);
    #2 rst_il = 1'b0;
    #1;
    check("abort_we", we_n[0], 1'b1);
    check("abort_ce", ce_n[0], 1'b1);
    check("abort_oe", oe_n[0], 1'b1);
    check("abort_dq", dq0, KEEP);
    check("abort_rdy", rdy[0], 1'b0);
    check("abort_coll", collision[0], 1'b0);
    vcount = 0;
    repeat (3) begin
      @(negedge clk);
      if (rd_valid[0]) vcount++;
    end
    check("abort_no_rdval", vcount, 0);
    rst_il = 1'b1;
    @(negedge clk);
    check("abort_recover_rdy", rdy[0], 1'b1);
    check("abort_recover_rdata", rd_data[0], 16'h0000);
    run_read(0, 18'h1A2B3, 16'hBEEF, "abort_rd");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time bound in case the directed sequence stalls
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
